pipeline_cpu: RTL and testbench

- 5-stage in-order MIPS32-subset pipeline: IF, ID, EX, MEM, WB.
- Instruction and data memories are external and combinational.
- Full forwarding.
- Branches and jumps resolve in ID with no delay slot; the wrong-path fetch is flushed.
- Load-use and branch-operand hazards stall; the stall is reported on remain_pc.

---
 rtl/pipeline_cpu.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_pipeline_cpu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_cpu.sv
// Five-stage in-order MIPS32-subset pipeline (IF, ID, EX, MEM, WB).
// Branches and jumps resolve in ID with a one-cycle flush. Forwarding covers
// EX operands, store data and the ID branch compare. Load-use hazards and
// branch-operand hazards stall the front end.
module pipeline_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_mem,
    output logic [31:0] data_addr,
    input  logic [31:0] data_mem,
    output logic        data_we,
    output logic [31:0] data_write,
    output logic        branch,
    output logic        remain_pc
);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
    } aluOp_e;

    // Architectural and pipeline state
    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];

    logic [31:0] ifIdInst_q, ifIdPc_q;

    aluOp_e      idExAluOp_q;
    logic        idExUseImm_q, idExRegWrite_q, idExMemRead_q, idExMemWrite_q;
    logic [31:0] idExImm_q, idExRsVal_q, idExRtVal_q;
    logic [4:0]  idExRs_q, idExRt_q, idExDest_q, idExShamt_q;

    logic        exMemRegWrite_q, exMemMemRead_q, exMemMemWrite_q;
    logic [4:0]  exMemDest_q;
    logic [31:0] exMemAlu_q, exMemStore_q;

    logic        memWbRegWrite_q;
    logic [4:0]  memWbDest_q;
    logic [31:0] memWbValue_q;

    // Instruction fields in ID
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [31:0] sextImm, pcPlus4Id;

    assign opcode    = ifIdInst_q[31:26];
    assign rs        = ifIdInst_q[25:21];
    assign rt        = ifIdInst_q[20:16];
    assign rd        = ifIdInst_q[15:11];
    assign shamt     = ifIdInst_q[10:6];
    assign funct     = ifIdInst_q[5:0];
    assign imm16     = ifIdInst_q[15:0];
    assign sextImm   = {{16{imm16[15]}}, imm16};
    assign pcPlus4Id = ifIdPc_q + 32'd4;

    // Decoded controls
    aluOp_e      decAluOp;
    logic        decUseImm, decRegWrite, decMemRead, decMemWrite;
    logic [31:0] decImm;
    logic [4:0]  decDest;
    logic        usesRs, usesRt, isBeq, isBne, isJ, isJal, isJr;

    // Decode the ID instruction; anything unrecognised stays a nop
    always_comb begin
        decAluOp    = ALU_ADD;
        decUseImm   = 1'b0;
        decRegWrite = 1'b0;
        decMemRead  = 1'b0;
        decMemWrite = 1'b0;
        decImm      = sextImm;
        decDest     = 5'd0;
        usesRs      = 1'b0;
        usesRt      = 1'b0;
        isBeq       = 1'b0;
        isBne       = 1'b0;
        isJ         = 1'b0;
        isJal       = 1'b0;
        isJr        = 1'b0;
        case (opcode)
            6'h00: begin
                decRegWrite = 1'b1;
                decDest     = rd;
                usesRs      = 1'b1;
                usesRt      = 1'b1;
                case (funct)
                    6'h20, 6'h21: decAluOp = ALU_ADD;
                    6'h22, 6'h23: decAluOp = ALU_SUB;
                    6'h24:        decAluOp = ALU_AND;
                    6'h25:        decAluOp = ALU_OR;
                    6'h26:        decAluOp = ALU_XOR;
                    6'h27:        decAluOp = ALU_NOR;
                    6'h2A:        decAluOp = ALU_SLT;
                    6'h2B:        decAluOp = ALU_SLTU;
                    6'h00: begin decAluOp = ALU_SLL; usesRs = 1'b0; end
                    6'h02: begin decAluOp = ALU_SRL; usesRs = 1'b0; end
                    6'h03: begin decAluOp = ALU_SRA; usesRs = 1'b0; end
                    6'h08: begin
                        isJr        = 1'b1;
                        usesRt      = 1'b0;
                        decRegWrite = 1'b0;
                        decDest     = 5'd0;
                    end
                    default: begin
                        decRegWrite = 1'b0;
                        decDest     = 5'd0;
                        usesRs      = 1'b0;
                        usesRt      = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: begin
                decUseImm   = 1'b1;
                decRegWrite = 1'b1;
                decDest     = rt;
                usesRs      = 1'b1;
                case (opcode)
                    6'h0A: decAluOp = ALU_SLT;
                    6'h0B: decAluOp = ALU_SLTU;
                    6'h0C: begin decAluOp = ALU_AND; decImm = {16'h0, imm16}; end
                    6'h0D: begin decAluOp = ALU_OR;  decImm = {16'h0, imm16}; end
                    6'h0E: begin decAluOp = ALU_XOR; decImm = {16'h0, imm16}; end
                    6'h0F: begin
                        decAluOp = ALU_PASSB;
                        decImm   = {imm16, 16'h0};
                        usesRs   = 1'b0;
                    end
                    6'h23:   decMemRead = 1'b1;
                    default: decAluOp = ALU_ADD;
                endcase
            end
            6'h2B: begin
                decUseImm   = 1'b1;
                decMemWrite = 1'b1;
                usesRs      = 1'b1;
                usesRt      = 1'b1;
            end
            6'h04: begin isBeq = 1'b1; usesRs = 1'b1; usesRt = 1'b1; end
            6'h05: begin isBne = 1'b1; usesRs = 1'b1; usesRt = 1'b1; end
            6'h02: isJ = 1'b1;
            6'h03: begin
                isJal       = 1'b1;
                decAluOp    = ALU_PASSB;
                decUseImm   = 1'b1;
                decImm      = pcPlus4Id;
                decRegWrite = 1'b1;
                decDest     = 5'd31;
            end
            default: decAluOp = ALU_ADD;
        endcase
    end

    // Register read with write-through of the value WB commits this cycle
    logic [31:0] rfRs, rfRt;
    always_comb begin
        rfRs = regs_q[rs];
        rfRt = regs_q[rt];
        if (memWbRegWrite_q && memWbDest_q != 5'd0 && memWbDest_q == rs) rfRs = memWbValue_q;
        if (memWbRegWrite_q && memWbDest_q != 5'd0 && memWbDest_q == rt) rfRt = memWbValue_q;
        if (rs == 5'd0) rfRs = 32'd0;
        if (rt == 5'd0) rfRt = 32'd0;
    end

    // Hazard detection: load-use in EX, and branch sources not yet resolvable
    logic loadUse, brExHaz, brMemHaz, stall, isBranchLike;
    logic matchExRs, matchExRt, matchMemRs, matchMemRt;
    always_comb begin
        isBranchLike = isBeq | isBne | isJr;
        matchExRs  = usesRs && idExDest_q != 5'd0 && idExDest_q == rs;
        matchExRt  = usesRt && idExDest_q != 5'd0 && idExDest_q == rt;
        matchMemRs = usesRs && exMemDest_q != 5'd0 && exMemDest_q == rs;
        matchMemRt = usesRt && exMemDest_q != 5'd0 && exMemDest_q == rt;
        loadUse    = idExMemRead_q && (matchExRs || matchExRt);
        brExHaz    = isBranchLike && idExRegWrite_q && (matchExRs || matchExRt);
        brMemHaz   = isBranchLike && exMemMemRead_q && (matchMemRs || matchMemRt);
        stall      = loadUse | brExHaz | brMemHaz;
    end

    // Branch compare operands forward from a completed ALU result in MEM
    logic [31:0] brRs, brRt, redirectTarget;
    logic        takeBranch;
    always_comb begin
        brRs = rfRs;
        brRt = rfRt;
        if (exMemRegWrite_q && !exMemMemRead_q && exMemDest_q != 5'd0 && exMemDest_q == rs) brRs = exMemAlu_q;
        if (exMemRegWrite_q && !exMemMemRead_q && exMemDest_q != 5'd0 && exMemDest_q == rt) brRt = exMemAlu_q;
        takeBranch = !stall && ((isBeq && brRs == brRt) || (isBne && brRs != brRt) || isJ || isJal || isJr);
        if (isJr)
            redirectTarget = brRs;
        else if (isJ || isJal)
            redirectTarget = {pcPlus4Id[31:28], ifIdInst_q[25:0], 2'b00};
        else
            redirectTarget = pcPlus4Id + {sextImm[29:0], 2'b00};
        if (stall)
            pc_d = pc_q;
        else if (takeBranch)
            pc_d = redirectTarget;
        else
            pc_d = pc_q + 32'd4;
    end

    // EX operand forwarding and ALU
    logic [31:0] fwdRs, fwdRt, aluB, aluResult;
    always_comb begin
        fwdRs = idExRsVal_q;
        fwdRt = idExRtVal_q;
        if (memWbRegWrite_q && memWbDest_q != 5'd0 && memWbDest_q == idExRs_q) fwdRs = memWbValue_q;
        if (memWbRegWrite_q && memWbDest_q != 5'd0 && memWbDest_q == idExRt_q) fwdRt = memWbValue_q;
        if (exMemRegWrite_q && !exMemMemRead_q && exMemDest_q != 5'd0 && exMemDest_q == idExRs_q) fwdRs = exMemAlu_q;
        if (exMemRegWrite_q && !exMemMemRead_q && exMemDest_q != 5'd0 && exMemDest_q == idExRt_q) fwdRt = exMemAlu_q;
        aluB = idExUseImm_q ? idExImm_q : fwdRt;
        case (idExAluOp_q)
            ALU_ADD:   aluResult = fwdRs + aluB;
            ALU_SUB:   aluResult = fwdRs - aluB;
            ALU_AND:   aluResult = fwdRs & aluB;
            ALU_OR:    aluResult = fwdRs | aluB;
            ALU_XOR:   aluResult = fwdRs ^ aluB;
            ALU_NOR:   aluResult = ~(fwdRs | aluB);
            ALU_SLT:   aluResult = {31'd0, $signed(fwdRs) < $signed(aluB)};
            ALU_SLTU:  aluResult = {31'd0, fwdRs < aluB};
            ALU_SLL:   aluResult = aluB << idExShamt_q;
            ALU_SRL:   aluResult = aluB >> idExShamt_q;
            ALU_SRA:   aluResult = $unsigned($signed(aluB) >>> idExShamt_q);
            ALU_PASSB: aluResult = aluB;
            default:   aluResult = 32'd0;
        endcase
    end

    // Front end: PC and IF/ID, held on stall, IF/ID flushed on redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            ifIdInst_q <= 32'd0;
            ifIdPc_q   <= 32'd0;
        end else begin
            pc_q <= pc_d;
            if (!stall) begin
                ifIdInst_q <= takeBranch ? 32'd0 : inst_mem;
                ifIdPc_q   <= pc_q;
            end
        end
    end

    // ID/EX: bubble inserted while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idExAluOp_q    <= ALU_ADD;
            idExUseImm_q   <= 1'b0;
            idExRegWrite_q <= 1'b0;
            idExMemRead_q  <= 1'b0;
            idExMemWrite_q <= 1'b0;
            idExImm_q      <= 32'd0;
            idExRsVal_q    <= 32'd0;
            idExRtVal_q    <= 32'd0;
            idExRs_q       <= 5'd0;
            idExRt_q       <= 5'd0;
            idExDest_q     <= 5'd0;
            idExShamt_q    <= 5'd0;
        end else begin
            idExAluOp_q    <= decAluOp;
            idExUseImm_q   <= decUseImm;
            idExRegWrite_q <= decRegWrite && !stall;
            idExMemRead_q  <= decMemRead && !stall;
            idExMemWrite_q <= decMemWrite && !stall;
            idExImm_q      <= decImm;
            idExRsVal_q    <= rfRs;
            idExRtVal_q    <= rfRt;
            idExRs_q       <= rs;
            idExRt_q       <= rt;
            idExDest_q     <= stall ? 5'd0 : decDest;
            idExShamt_q    <= shamt;
        end
    end

    // EX/MEM and MEM/WB, with load data sampled on the way into WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exMemRegWrite_q <= 1'b0;
            exMemMemRead_q  <= 1'b0;
            exMemMemWrite_q <= 1'b0;
            exMemDest_q     <= 5'd0;
            exMemAlu_q      <= 32'd0;
            exMemStore_q    <= 32'd0;
            memWbRegWrite_q <= 1'b0;
            memWbDest_q     <= 5'd0;
            memWbValue_q    <= 32'd0;
        end else begin
            exMemRegWrite_q <= idExRegWrite_q;
            exMemMemRead_q  <= idExMemRead_q;
            exMemMemWrite_q <= idExMemWrite_q;
            exMemDest_q     <= idExDest_q;
            exMemAlu_q      <= aluResult;
            exMemStore_q    <= fwdRt;
            memWbRegWrite_q <= exMemRegWrite_q;
            memWbDest_q     <= exMemDest_q;
            memWbValue_q    <= exMemMemRead_q ? data_mem : exMemAlu_q;
        end
    end

    // Register file write in WB; $0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else if (memWbRegWrite_q && memWbDest_q != 5'd0) begin
            regs_q[memWbDest_q] <= memWbValue_q;
        end
    end

    assign inst_addr  = pc_q;
    assign data_addr  = exMemAlu_q;
    assign data_write = exMemStore_q;
    assign data_we    = exMemMemWrite_q;
    assign branch     = takeBranch;
    assign remain_pc  = stall;

endmodule

// File: tb/tb_pipeline_cpu.sv
// Directed-program testbench for pipeline_cpu with behavioural instruction
// and data memories and hand-computed expected bus activity.
module tb_pipeline_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_addr, inst_mem, data_addr, data_mem, data_write;
    logic        data_we, branch, remain_pc;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    int vectors     = 0;
    int miscompares = 0;

    pipeline_cpu #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_addr  (inst_addr),
        .inst_mem   (inst_mem),
        .data_addr  (data_addr),
        .data_mem   (data_mem),
        .data_we    (data_we),
        .data_write (data_write),
        .branch     (branch),
        .remain_pc  (remain_pc)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Combinational memories, word-indexed over a small window
    assign inst_mem = imem[inst_addr[7:2]];
    assign data_mem = dmem[data_addr[7:2]];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int edges);
        repeat (edges) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearMemories();
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'd0;
            dmem[i] = 32'd0;
        end
    endtask

    // Asserts reset between edges, checks the reset outputs, releases it so the
    // next rising edge is edge 1 of the program
    task automatic resetDut(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput({tag, " rst inst_addr"}, inst_addr, 32'h0);
        checkOutput({tag, " rst data_addr"}, data_addr, 32'h0);
        checkOutput({tag, " rst data_write"}, data_write, 32'h0);
        checkOutput({tag, " rst data_we"}, data_we, 32'h0);
        checkOutput({tag, " rst branch"}, branch, 32'h0);
        checkOutput({tag, " rst remain_pc"}, remain_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic loadArithProgram();
        imem[0] = 32'h2004_0003; // addi $4,$0,3
        imem[1] = 32'h2005_0004; // addi $5,$0,4
        imem[2] = 32'h0085_3020; // add  $6,$4,$5
        imem[3] = 32'h3C07_E000; // lui  $7,0xE000
        imem[4] = 32'hACE6_0000; // sw   $6,0($7)
    endtask

    initial begin
        // Straight-line arithmetic with forwarding into a store
        clearMemories();
        loadArithProgram();
        resetDut("t1");
        checkOutput("t1 pc start", inst_addr, 32'h0);
        for (int e = 1; e <= 7; e++) begin
            applyStimulus(1);
            checkOutput("t1 pc step", inst_addr, 32'(4 * e));
            checkOutput("t1 remain_pc", remain_pc, 32'h0);
            checkOutput("t1 branch", branch, 32'h0);
            if (e == 6) checkOutput("t1 we early", data_we, 32'h0);
        end
        checkOutput("t1 data_we", data_we, 32'h1);
        checkOutput("t1 data_addr", data_addr, 32'hE000_0000);
        checkOutput("t1 data_write", data_write, 32'h7);

        // Reset with the store in flight must discard it
        clearMemories();
        loadArithProgram();
        resetDut("t2a");
        applyStimulus(6);
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
        resetDut("t2b");
        for (int e = 1; e <= 8; e++) begin
            applyStimulus(1);
            checkOutput("t2 no stale store", data_we, 32'h0);
        end

        // Load-use stall then store of the doubled load value
        clearMemories();
        dmem[0] = 32'h55;
        imem[0] = 32'h8C02_0000; // lw  $2,0($0)
        imem[1] = 32'h0042_1820; // add $3,$2,$2
        imem[2] = 32'hAC03_0004; // sw  $3,4($0)
        resetDut("t3");
        applyStimulus(1);
        checkOutput("t3 no stall e1", remain_pc, 32'h0);
        applyStimulus(1);
        checkOutput("t3 stall e2", remain_pc, 32'h1);
        checkOutput("t3 pc e2", inst_addr, 32'h8);
        applyStimulus(1);
        checkOutput("t3 stall over e3", remain_pc, 32'h0);
        checkOutput("t3 pc held e3", inst_addr, 32'h8);
        applyStimulus(1);
        checkOutput("t3 pc e4", inst_addr, 32'hC);
        applyStimulus(2);
        checkOutput("t3 data_we", data_we, 32'h1);
        checkOutput("t3 data_addr", data_addr, 32'h4);
        checkOutput("t3 data_write", data_write, 32'hAA);

        // Taken beq flushes the wrong-path store
        clearMemories();
        imem[0] = 32'h2008_0001; // addi $8,$0,1
        imem[2] = 32'h1000_0003; // beq  $0,$0,+3
        imem[3] = 32'hAC08_0000; // sw   $8,0($0)   wrong path
        imem[4] = 32'hAC08_0004; // sw   $8,4($0)   skipped
        imem[5] = 32'hAC08_000C; // sw   $8,12($0)  skipped
        imem[6] = 32'hAC08_0008; // sw   $8,8($0)   target
        resetDut("t4");
        applyStimulus(3);
        checkOutput("t4 branch", branch, 32'h1);
        checkOutput("t4 remain_pc", remain_pc, 32'h0);
        applyStimulus(1);
        checkOutput("t4 target pc", inst_addr, 32'h18);
        checkOutput("t4 branch low", branch, 32'h0);
        applyStimulus(1);
        checkOutput("t4 no store e5", data_we, 32'h0);
        applyStimulus(1);
        checkOutput("t4 flushed store", data_we, 32'h0);
        applyStimulus(1);
        checkOutput("t4 data_we", data_we, 32'h1);
        checkOutput("t4 data_addr", data_addr, 32'h8);
        checkOutput("t4 data_write", data_write, 32'h1);

        // bne not taken, then jal/jr round trip storing the link value
        clearMemories();
        imem[0]  = 32'h2009_0005; // addi $9,$0,5
        imem[1]  = 32'h200A_0005; // addi $10,$0,5
        imem[4]  = 32'h152A_0004; // bne  $9,$10,+4
        imem[5]  = 32'h0C00_0010; // jal  0x40
        imem[6]  = 32'hAC1F_000C; // sw   $31,12($0)
        imem[16] = 32'h03E0_0008; // jr   $31
        resetDut("t5");
        applyStimulus(5);
        checkOutput("t5 bne branch", branch, 32'h0);
        checkOutput("t5 bne pc", inst_addr, 32'h14);
        applyStimulus(1);
        checkOutput("t5 jal branch", branch, 32'h1);
        applyStimulus(1);
        checkOutput("t5 jal target", inst_addr, 32'h40);
        applyStimulus(1);
        checkOutput("t5 jr branch", branch, 32'h1);
        checkOutput("t5 jr remain_pc", remain_pc, 32'h0);
        applyStimulus(1);
        checkOutput("t5 return pc", inst_addr, 32'h18);
        checkOutput("t5 no store e9", data_we, 32'h0);
        applyStimulus(1);
        checkOutput("t5 no store e10", data_we, 32'h0);
        applyStimulus(1);
        checkOutput("t5 no store e11", data_we, 32'h0);
        applyStimulus(1);
        checkOutput("t5 data_we", data_we, 32'h1);
        checkOutput("t5 data_addr", data_addr, 32'hC);
        checkOutput("t5 link value", data_write, 32'h18);

        // $0 stays zero and an undefined opcode has no effect
        clearMemories();
        imem[0] = 32'h2000_0005; // addi $0,$0,5
        imem[1] = 32'hFC0B_1234; // undefined opcode
        imem[2] = 32'hAC00_0000; // sw   $0,0($0)
        imem[3] = 32'hAC0B_0004; // sw   $11,4($0)
        resetDut("t6");
        applyStimulus(4);
        checkOutput("t6 undefined no store", data_we, 32'h0);
        applyStimulus(1);
        checkOutput("t6 sw0 we", data_we, 32'h1);
        checkOutput("t6 sw0 data", data_write, 32'h0);
        applyStimulus(1);
        checkOutput("t6 sw11 addr", data_addr, 32'h4);
        checkOutput("t6 sw11 data", data_write, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
